m_serial_tx_arbiter: RTL and testbench

// - Shares one byte-serial transmitter (start pulse / 8-bit data / busy) between NUM_REQ requesters.
// - Round-robin byte grants, optional per-requester lock for multi-byte packets, inter-byte gap,

---
 rtl/m_serial_tx_arbiter_pkg.sv | 21 ++
 rtl/m_serial_tx_arbiter_if.sv | 29 ++
 rtl/m_rr_pick.sv | 33 +++
 rtl/m_serial_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_m_serial_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_serial_tx_arbiter_pkg.sv
// Shared types and constants for the serial TX arbiter.
package m_serial_tx_arbiter_pkg;

  // Width of a requester index; covers up to MAX_REQ requesters.
  localparam int GRANT_W = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  // One-hot decode of a requester index into the widest request vector.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [GRANT_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/m_serial_tx_arbiter_if.sv
// Requester and transmitter signals of the serial TX arbiter.
interface m_serial_tx_arbiter_if
  import m_serial_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_lock;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [GRANT_W-1:0]   grant_id;
  logic                 active;
  logic                 err_timeout;

  // Arbiter side.
  modport master (
    input  req_valid, req_lock, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, active, err_timeout
  );

  // Requesters plus transmitter side.
  modport slave (
    output req_valid, req_lock, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, active, err_timeout
  );
endinterface

// File: rtl/m_rr_pick.sv
// Combinational round-robin picker: first valid requester after the last grant.
module m_rr_pick
  import m_serial_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] winner,
  output logic               found
);

  logic [MAX_REQ-1:0] valid_ext;

  assign valid_ext = MAX_REQ'(req_valid);

  // Search last+1, last+2, ... modulo NUM_REQ; the first hit wins.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    winner = last;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && valid_ext[idx[GRANT_W-1:0]]) begin
        winner = idx[GRANT_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_serial_tx_arbiter.sv
// Shares one byte-serial transmitter between NUM_REQ requesters with round-robin
// byte grants, optional owner lock, a forced inter-byte gap and a busy-start timeout.
module m_serial_tx_arbiter
  import m_serial_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 4095
) (
  input logic                  clk,
  input logic                  rst,
  m_serial_tx_arbiter_if.master bus
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t               state;
  logic [GAP_W-1:0]     gap_cnt;
  logic [11:0]          to_cnt;
  logic                 lock_own;
  logic [NUM_REQ-1:0]   ready_q;
  logic                 start_q;
  logic [7:0]           data_q;
  logic [GRANT_W-1:0]   grant_q;
  logic                 active_q;
  logic                 err_q;

  logic [MAX_REQ-1:0]   valid_ext;
  logic [MAX_REQ-1:0]   lock_ext;
  logic [8*MAX_REQ-1:0] data_ext;
  logic [GRANT_W-1:0]   rr_win;
  logic                 rr_found;
  logic                 owner_hold;
  logic [GRANT_W-1:0]   win;
  logic                 win_ok;

  // Pad request vectors to the widest size so a 3-bit index is always in range.
  assign valid_ext = MAX_REQ'(bus.req_valid);
  assign lock_ext  = MAX_REQ'(bus.req_lock);
  assign data_ext  = (8*MAX_REQ)'(bus.req_data);

  m_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (bus.req_valid),
    .last      (grant_q),
    .winner    (rr_win),
    .found     (rr_found)
  );

  // A locked owner whose lock is still up waits alone; otherwise round-robin decides.
  always_comb begin
    owner_hold = lock_own & lock_ext[grant_q];
    win        = owner_hold ? grant_q : rr_win;
    win_ok     = owner_hold ? valid_ext[grant_q] : rr_found;
  end

  // Grant FSM with counters, lock ownership and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments, and every register (data included) is
    // cleared by the async reset so an aborted byte leaves no stale pulse or data behind.
    if (rst) begin
      state    <= ST_IDLE;
      gap_cnt  <= '0;
      to_cnt   <= '0;
      lock_own <= 1'b0;
      ready_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= 8'h00;
      grant_q  <= GRANT_W'(NUM_REQ - 1);
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= '0;
      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (lock_own && !lock_ext[grant_q]) lock_own <= 1'b0;
          if (win_ok) begin
            data_q   <= data_ext[{win, 3'b000} +: 8];
            grant_q  <= win;
            ready_q  <= NUM_REQ'(onehot(win));
            start_q  <= 1'b1;
            lock_own <= lock_ext[win];
            active_q <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          to_cnt <= '0;
          state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (to_cnt == 12'(BUSY_TIMEOUT - 1)) begin
            // Transmitter never started: drop the byte and release any lock.
            err_q    <= 1'b1;
            lock_own <= 1'b0;
            gap_cnt  <= '0;
            state    <= ST_GAP;
          end else begin
            to_cnt <= to_cnt + 12'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            active_q <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          active_q <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.tx_start    = start_q;
  assign bus.tx_data     = data_q;
  assign bus.grant_id    = grant_q;
  assign bus.active      = active_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_m_serial_tx_arbiter.sv
// Directed bench for m_serial_tx_arbiter: vector table plus multi-cycle sequences.
module tb_m_serial_tx_arbiter;
  import m_serial_tx_arbiter_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int GAP_CYCLES   = 16;
  localparam int BUSY_TIMEOUT = 4095;

  logic clk;
  logic rst;
  m_serial_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  m_serial_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int start_cnt = 0;
  int fall_cyc  = 0;
  bit busy_en   = 1'b1;
  int dly  = 0;
  int hcnt = 0;

  typedef struct {
    logic [3:0] valid;
    int         exp_id;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs [12];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises 2 cycles after tx_start and stays high 20 cycles.
  always @(negedge clk) begin
    if (rst) begin
      bus.tx_busy = 1'b0;
      dly  = 0;
      hcnt = 0;
    end else begin
      if (bus.tx_start) start_cnt++;
      if (bus.tx_start && busy_en) begin
        dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          bus.tx_busy = 1'b1;
          hcnt = 20;
        end
      end else if (hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) begin
          bus.tx_busy = 1'b0;
          fall_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_data  = '0;
    busy_en = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  task automatic set_data(input int n);
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[8*i +: 8] = 8'(16*n + i);
  endtask

  task automatic wait_accept(output int idx, output bit ok);
    idx = -1;
    ok  = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      step();
      if (bus.req_ready != '0) begin
        ok = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) idx = i;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      step();
      if (!bus.active) ok = 1'b1;
    end
  endtask

  initial begin
    int idx;
    bit ok;
    int got [5];
    int n1;
    int s0;
    int t0;
    int seen;

    vecs[0]  = '{4'b0001, 0, 8'h00};
    vecs[1]  = '{4'b1111, 1, 8'h11};
    vecs[2]  = '{4'b1111, 2, 8'h22};
    vecs[3]  = '{4'b1111, 3, 8'h33};
    vecs[4]  = '{4'b1111, 0, 8'h40};
    vecs[5]  = '{4'b1010, 1, 8'h51};
    vecs[6]  = '{4'b1010, 3, 8'h63};
    vecs[7]  = '{4'b0100, 2, 8'h72};
    vecs[8]  = '{4'b1001, 3, 8'h83};
    vecs[9]  = '{4'b0011, 0, 8'h90};
    vecs[10] = '{4'b0110, 1, 8'hA1};
    vecs[11] = '{4'b0001, 0, 8'hB0};

    // Reset values.
    reset_dut();
    check("rst_ready",  32'(bus.req_ready), 0);
    check("rst_start",  32'(bus.tx_start), 0);
    check("rst_data",   32'(bus.tx_data), 0);
    check("rst_grant",  32'(bus.grant_id), 3);
    check("rst_active", 32'(bus.active), 0);
    check("rst_err",    32'(bus.err_timeout), 0);

    // Single byte from requester 0, then a second byte to measure the gap.
    bus.req_data[7:0] = 8'h55;
    bus.req_valid = 4'b0001;
    wait_accept(idx, ok);
    check("t1_accept", 32'(ok), 1);
    check("t1_ready",  32'(bus.req_ready), 32'h1);
    check("t1_start",  32'(bus.tx_start), 1);
    check("t1_data",   32'(bus.tx_data), 32'h55);
    check("t1_active", 32'(bus.active), 1);
    bus.req_data[7:0] = 8'h66;
    step();
    check("t1_ready_pulse", 32'(bus.req_ready), 0);
    check("t1_start_pulse", 32'(bus.tx_start), 0);
    repeat (10) step();
    check("t1_data_stable", 32'(bus.tx_data), 32'h55);
    wait_accept(idx, ok);
    check("t1_accept2", 32'(ok), 1);
    check("t1_gap", 32'((cyc - fall_cyc) >= GAP_CYCLES), 1);
    check("t1_data2", 32'(bus.tx_data), 32'h66);
    check("t1_start_cnt", 32'(start_cnt), 2);
    bus.req_valid = '0;
    wait_idle(ok);
    check("t1_idle", 32'(ok), 1);

    // Vector table: one byte per record, grant order follows from reset.
    reset_dut();
    for (int v = 0; v < 12; v++) begin
      set_data(v);
      bus.req_valid = vecs[v].valid;
      wait_accept(idx, ok);
      check($sformatf("vec%0d_accept", v), 32'(ok), 1);
      check($sformatf("vec%0d_id", v), 32'(idx), 32'(vecs[v].exp_id));
      check($sformatf("vec%0d_grant", v), 32'(bus.grant_id), 32'(vecs[v].exp_id));
      check($sformatf("vec%0d_onehot", v), 32'(bus.req_ready), 32'(1) << vecs[v].exp_id);
      check($sformatf("vec%0d_start", v), 32'(bus.tx_start), 1);
      check($sformatf("vec%0d_data", v), 32'(bus.tx_data), 32'(vecs[v].exp_data));
      bus.req_valid = '0;
      wait_idle(ok);
      check($sformatf("vec%0d_idle", v), 32'(ok), 1);
    end

    // All four valid continuously, no lock.
    reset_dut();
    set_data(0);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_accept(idx, ok);
      check("rr_accept", 32'(ok), 1);
      got[k] = idx;
    end
    bus.req_valid = '0;
    check("rr_g0", 32'(got[0]), 0);
    check("rr_g1", 32'(got[1]), 1);
    check("rr_g2", 32'(got[2]), 2);
    check("rr_g3", 32'(got[3]), 3);
    check("rr_g4", 32'(got[4]), 0);
    wait_idle(ok);

    // Requester 1 locks for three bytes while 0 and 2 wait.
    reset_dut();
    set_data(1);
    bus.req_valid = 4'b0010;
    bus.req_lock  = 4'b0010;
    n1 = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept(idx, ok);
      check("lock_accept", 32'(ok), 1);
      got[k] = idx;
      if (k == 0) bus.req_valid = 4'b0111;
      if (idx == 1) begin
        n1++;
        if (n1 == 3) begin
          bus.req_valid[1] = 1'b0;
          bus.req_lock[1]  = 1'b0;
        end
      end else if (idx >= 0) begin
        bus.req_valid[idx] = 1'b0;
      end
    end
    check("lock_g0", 32'(got[0]), 1);
    check("lock_g1", 32'(got[1]), 1);
    check("lock_g2", 32'(got[2]), 1);
    check("lock_g3", 32'(got[3]), 2);
    check("lock_g4", 32'(got[4]), 0);
    bus.req_valid = '0;
    wait_idle(ok);

    // Owner drops valid but keeps lock: others wait; dropping lock hands over at once.
    reset_dut();
    set_data(2);
    bus.req_valid = 4'b0010;
    bus.req_lock  = 4'b0010;
    wait_accept(idx, ok);
    check("drop_first", 32'(idx), 1);
    bus.req_valid = 4'b0100;
    wait_idle(ok);
    check("drop_idle", 32'(ok), 1);
    seen = 0;
    repeat (20) begin
      step();
      if (bus.req_ready != '0) seen++;
    end
    check("drop_held", 32'(seen), 0);
    bus.req_lock = 4'b0000;
    step();
    check("drop_ready", 32'(bus.req_ready), 32'b0100);
    check("drop_grant", 32'(bus.grant_id), 2);
    bus.req_valid = '0;
    wait_idle(ok);

    // Transmitter never goes busy: timeout, sticky error.
    reset_dut();
    busy_en = 1'b0;
    set_data(3);
    bus.req_valid = 4'b0001;
    wait_accept(idx, ok);
    check("to_accept", 32'(ok), 1);
    t0 = cyc;
    bus.req_valid = '0;
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      step();
      if (bus.err_timeout) ok = 1'b1;
    end
    check("to_err_set", 32'(ok), 1);
    check("to_elapsed", 32'((cyc - t0) >= BUSY_TIMEOUT && (cyc - t0) <= BUSY_TIMEOUT + 1), 1);
    wait_idle(ok);
    check("to_idle", 32'(ok), 1);
    check("to_sticky1", 32'(bus.err_timeout), 1);
    busy_en = 1'b1;
    bus.req_valid = 4'b0001;
    wait_accept(idx, ok);
    check("to_next_accept", 32'(ok), 1);
    bus.req_valid = '0;
    wait_idle(ok);
    check("to_sticky2", 32'(bus.err_timeout), 1);

    // Reset asserted while the transmitter is busy.
    reset_dut();
    bus.req_data[7:0] = 8'hA5;
    bus.req_valid = 4'b0001;
    wait_accept(idx, ok);
    bus.req_valid = '0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      step();
      if (bus.tx_busy) ok = 1'b1;
    end
    check("mid_busy_seen", 32'(ok), 1);
    repeat (3) step();
    check("mid_pre_data", 32'(bus.tx_data), 32'hA5);
    rst = 1'b1;
    #1;
    check("mid_ready",  32'(bus.req_ready), 0);
    check("mid_start",  32'(bus.tx_start), 0);
    check("mid_data",   32'(bus.tx_data), 0);
    check("mid_grant",  32'(bus.grant_id), 3);
    check("mid_active", 32'(bus.active), 0);
    repeat (2) step();
    rst = 1'b0;
    s0 = start_cnt;
    repeat (50) step();
    check("mid_no_start", 32'(start_cnt - s0), 0);
    check("mid_still_idle", 32'(bus.active), 0);
    bus.req_valid = 4'b0001;
    wait_accept(idx, ok);
    check("mid_restart", 32'(idx), 0);
    bus.req_valid = '0;
    wait_idle(ok);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
